// File: rtl/memory_writer.sv
// memory_writer: write-side initiator for the 4 x 8-bit memory_system store.
// Accepts bytes over valid/ready and drives data/store/addr with a
// setup / strobe / hold sequence so the level-sensitive byte latches capture
// cleanly. Writes walk a loadable 2-bit pointer that wraps 3 -> 0.
//
// Optional feature macro: MEMORY_WRITER_READBACK_EN adds a VERIFY state, the
// `memory` readback input and the sticky `mismatch` output.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/in_valid      producer byte and valid
//   in_ready              writer idle, can accept
//   load_addr/start_addr  load write pointer (honoured in IDLE only)
//   data/store/addr       to memory_system
//   next_addr             current write pointer
//   busy                  any state other than IDLE
//   wrap                  one-cycle pulse after a write to address 3 completes
//   memory/mismatch       readback input and sticky error (macro only)
module memory_writer #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       load_addr,
  input  logic [1:0] start_addr,
  output logic [7:0] data,
  output logic       store,
  output logic [1:0] addr,
  output logic [1:0] next_addr,
  output logic       busy,
  output logic       wrap
`ifdef MEMORY_WRITER_READBACK_EN
  ,
  input  logic [7:0] memory,
  output logic       mismatch
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    VERIFY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                store_q, store_d;
  logic                wrap_q, wrap_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done;
`ifdef MEMORY_WRITER_READBACK_EN
  logic                mismatch_q, mismatch_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tgt_d   = tgt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    store_d = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    done    = 1'b0;
`ifdef MEMORY_WRITER_READBACK_EN
    mismatch_d = mismatch_q;
`endif

    case (state_q)
      IDLE: begin
        // A same-cycle load redirects both the pointer and this write's target.
        if (load_addr) ptr_d = start_addr;
        addr_d = ptr_d;
        if (in_valid && ready_q) begin
          tgt_d   = ptr_d;
          data_d  = in_data;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        store_d = 1'b1;
        cnt_d   = STROBE_LOAD;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          store_d = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
`ifdef MEMORY_WRITER_READBACK_EN
        state_d = VERIFY;
`else
        done = 1'b1;
`endif
      end
`ifdef MEMORY_WRITER_READBACK_EN
      VERIFY: begin
        if (memory != data_q) mismatch_d = 1'b1;
        done = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Write complete: advance pointer past the target and flag a wrap.
    if (done) begin
      state_d = IDLE;
      ptr_d   = ADDR_W'(tgt_q + ADDR_W'(1));
      addr_d  = ptr_d;
      wrap_d  = (tgt_q == ADDR_W'(3));
    end

    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tgt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef MEMORY_WRITER_READBACK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
`ifdef MEMORY_WRITER_READBACK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign in_ready  = ready_q;
  assign busy      = busy_q;
  assign data      = data_q;
  assign store     = store_q;
  assign addr      = addr_q;
  assign next_addr = ptr_q;
  assign wrap      = wrap_q;
`ifdef MEMORY_WRITER_READBACK_EN
  assign mismatch  = mismatch_q;
`endif

endmodule
